uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 The block SHALL have port CLK  input  1  TX bit clock, where one CLK period equals one bit time; all logic is on the rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port P_DATA  input  DATA_WIDTH  parallel payload, valid when Data_Valid=1.
REQ-005 The block SHALL have port Data_Valid  input  1  one-cycle or level request to send P_DATA.
REQ-006 The block SHALL have port PAR_EN  input  1  1 = append a parity bit.
REQ-007 The block SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 The block SHALL have port TX_OUT  output  1  serial line, idle high, registered.
REQ-009 The block SHALL have port Busy  output  1  frame in progress, registered.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, a rising edge with Data_Valid=1 SHALL:
- latch P_DATA, PAR_EN and PAR_TYP into shadow registers;
- move the FSM to START.
REQ-012 The shadow registers SHALL NOT change until the next acceptance, so input changes mid-frame have no effect.
REQ-013 Data_Valid SHALL be ignored in every state other than IDLE; requests are neither queued nor counted.
REQ-014 Line levels per state:
- START drives TX_OUT=0 for exactly one cycle.
- DATA drives the latched bits LSB first, one per cycle, for DATA_WIDTH cycles.
- PARITY drives one parity bit, only when latched PAR_EN=1.
- STOP drives TX_OUT=1 for one cycle.
REQ-015 Transitions:
- START -> DATA.
- DATA -> PARITY after bit DATA_WIDTH-1 if PAR_EN=1, else DATA -> STOP.
- PARITY -> STOP.
- STOP -> IDLE.
REQ-016 The bit counter SHALL be $clog2(DATA_WIDTH) bits wide, SHALL clear on entry to DATA, and SHALL increment once per DATA cycle.
REQ-017 The parity bit SHALL be the XOR of the latched data when PAR_TYP=0, and its inverse when PAR_TYP=1, computed from the shadow register.
REQ-018 Cycle timing, with acceptance at rising edge k:
- TX_OUT=0 and Busy=1 in the cycle after edge k.
- Data bit i appears in the cycle after edge k+1+i.
- The frame is DATA_WIDTH+2 cycles long without parity and DATA_WIDTH+3 with parity.
REQ-019 Busy SHALL be 1 in every START, DATA, PARITY and STOP cycle, and 0 in IDLE.
REQ-020 With Data_Valid held high continuously, at least one IDLE cycle (TX_OUT=1, Busy=0) SHALL separate consecutive frames.
REQ-021 In IDLE, TX_OUT SHALL be 1 regardless of the other inputs.

Reset
REQ-022 At any rising edge with RST=0, the block SHALL return to IDLE with:
- TX_OUT=1 and Busy=0;
- bit counter=0;
- shadow data, PAR_EN and PAR_TYP = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame at that edge, with no partial stop bit; Data_Valid sampled at that edge SHALL be discarded.
REQ-024 RST SHALL have no effect between clock edges; the block has no asynchronous path.

Verification
REQ-025 Scenario 1: P_DATA=0xA5, PAR_EN=0, Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles), Busy high for those 10 cycles, then TX_OUT=1 and Busy=0.
REQ-026 Scenario 2: P_DATA=0x07 with PAR_EN=1:
- PAR_TYP=0 -> parity bit 1, 11-cycle frame.
- PAR_TYP=1 -> parity bit 0.
REQ-027 Scenario 3: P_DATA=0xA5 accepted, then Data_Valid=1 with P_DATA=0xFF and PAR_EN toggled during bit 3 -> transmitted frame unchanged (0xA5, no parity), no second frame.
REQ-028 Scenario 4: Data_Valid held high with P_DATA=0x3C -> repeated 10-cycle frames separated by exactly one IDLE cycle with TX_OUT=1 and Busy=0.
REQ-029 Scenario 5: RST=0 for one edge during data bit 4 -> next cycle TX_OUT=1, Busy=0; a subsequent 0x81 request produces a clean full frame.
REQ-030 Scenario 6: RST pulsed low between clock edges only (deasserted before the next rising edge) -> no change on TX_OUT or Busy.

Source files
------------

// File: rtl/uart_tx.sv
// ------------------------------------------------------------------
// uart_tx : serial transmitter, start / data LSB first / parity / stop
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [DATA_WIDTH-1:0] data_q,    data_d;
   logic                  par_en_q,  par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_q,      tx_d;
   logic                  busy_q,    busy_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;

      case (state_q)
         IDLE: begin
            if (Data_Valid) begin
               data_d    = P_DATA;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               state_d   = START;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            if (cnt_q == LAST_BIT) begin
               state_d = par_en_q ? PARITY : STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY:  state_d = STOP;
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Line level is decoded from the next state so TX_OUT stays a plain flop.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_q[cnt_d];
         PARITY:  tx_d = (^data_q) ^ par_typ_q;
         default: tx_d = 1'b1;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ------------------------------------------------------------------
// tb_uart_tx : self-checking bench for uart_tx against a frame model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

   localparam int DW = 8;

   logic          CLK        = 1'b0;
   logic          RST        = 1'b0;
   logic [DW-1:0] P_DATA     = '0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN     = 1'b0;
   logic          PAR_TYP    = 1'b0;
   logic          TX_OUT;
   logic          Busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic exp_bits [0:DW+2];
   int   exp_len;

   uart_tx #(.DATA_WIDTH(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .TX_OUT    (TX_OUT),
      .Busy      (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected line levels of a whole frame, one entry per bit time.
   task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
      int ones = 0;
      int idx;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < DW; i++) begin
         exp_bits[1+i] = d[i];
         ones += int'(d[i]);
      end
      idx = DW + 1;
      if (pe) begin
         exp_bits[idx] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
         idx++;
      end
      exp_bits[idx] = 1'b1;
      exp_len = idx + 1;
   endtask

   // mode: 0 quiet inputs, 1 random input churn, 2 late request with changed
   // data during bit 3, 3 Data_Valid held high throughout
   task automatic run_frame(input string name, input logic [DW-1:0] d, input logic pe,
                            input logic pt, input int mode, input int glitch_idx);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
      build_frame(d, pe, pt);
      tick();
      if (mode != 3) Data_Valid = 1'b0;
      for (int i = 0; i < exp_len; i++) begin
         if (i == glitch_idx) begin
            RST = 1'b0;
            #2;
            RST = 1'b1;
         end
         n_checks++;
         if (TX_OUT !== exp_bits[i]) begin
            n_fail++;
            $display("FAIL %s bit-time %0d: TX_OUT=%b expected %b", name, i, TX_OUT, exp_bits[i]);
         end
         n_checks++;
         if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy %0d: Busy=%b expected 1", name, i, Busy);
         end
         if (mode == 1) begin
            P_DATA = DW'($urandom); PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom); Data_Valid = 1'($urandom);
         end
         if (mode == 2 && i == 4) begin
            Data_Valid = 1'b1; P_DATA = '1; PAR_EN = ~PAR_EN;
         end
         tick();
      end
      n_checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle-after: TX_OUT=%b Busy=%b expected 1 0", name, TX_OUT, Busy);
      end
      if (mode != 3) Data_Valid = 1'b0;
   endtask

   task automatic idle_cycles(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         n_checks++;
         if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle %0d: TX_OUT=%b Busy=%b expected 1 0", name, i, TX_OUT, Busy);
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b0; Data_Valid = 1'b1; P_DATA = 8'h00;
      tick(); tick();
      n_checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: TX_OUT=%b Busy=%b expected 1 0", TX_OUT, Busy);
      end
      RST = 1'b1; Data_Valid = 1'b0;
      idle_cycles("reset_release", 2);
   endtask

   task automatic test_idle_inputs();
      for (int i = 0; i < 4; i++) begin
         P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
         idle_cycles("idle_inputs", 1);
      end
   endtask

   task automatic test_basic();
      run_frame("a5_noparity", 8'hA5, 1'b0, 1'b0, 0, -1);
      idle_cycles("a5_after", 1);
   endtask

   task automatic test_parity();
      run_frame("07_even", 8'h07, 1'b1, 1'b0, 0, -1);
      idle_cycles("07_even_after", 1);
      run_frame("07_odd", 8'h07, 1'b1, 1'b1, 0, -1);
      idle_cycles("07_odd_after", 1);
   endtask

   task automatic test_midframe_change();
      run_frame("shadow", 8'hA5, 1'b0, 1'b0, 2, -1);
      idle_cycles("no_second_frame", 3);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) run_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 3, -1);
      Data_Valid = 1'b0;
      idle_cycles("b2b_end", 2);
   endtask

   task automatic test_reset_midframe();
      P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      build_frame(8'h5A, 1'b1, 1'b0);
      tick();
      Data_Valid = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         n_checks++;
         if (TX_OUT !== exp_bits[i] || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid pre %0d: TX_OUT=%b Busy=%b expected %b 1", i, TX_OUT, Busy, exp_bits[i]);
         end
         if (i < 5) tick();
      end
      RST = 1'b0; Data_Valid = 1'b1;
      tick();
      n_checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid abort: TX_OUT=%b Busy=%b expected 1 0", TX_OUT, Busy);
      end
      RST = 1'b1; Data_Valid = 1'b0;
      idle_cycles("rst_mid_discard", 2);
      run_frame("post_reset_81", 8'h81, 1'b0, 1'b0, 0, -1);
      idle_cycles("post_reset_after", 1);
   endtask

   task automatic test_async_glitch();
      run_frame("glitch_mid", 8'hC3, 1'b1, 1'b0, 0, 3);
      RST = 1'b0;
      #2;
      RST = 1'b1;
      idle_cycles("glitch_idle", 1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         run_frame("random", DW'($urandom), 1'($urandom), 1'($urandom), 1, -1);
         idle_cycles("random_gap", int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_idle_inputs();
      test_basic();
      test_parity();
      test_midframe_change();
      test_back_to_back();
      test_reset_midframe();
      test_async_glitch();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
